// File: rtl/reg_file.sv
// Two-read, one-write register file with register 0 hardwired to zero.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              wr_en;

  // Writes to register 0 are dropped so it never holds anything but zero.
  assign wr_en = we && (waddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic fwd1;
  logic fwd2;

  // Forwarding is gated by reset so a held-off write cannot leak to the read ports.
  assign fwd1 = rst_n && wr_en && (raddr1 == waddr);
  assign fwd2 = rst_n && wr_en && (raddr2 == waddr);

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (fwd1) begin
      rdata1 = wdata;
    end else if (raddr1 != '0) begin
      rdata1 = regs_q[raddr1];
    end
    if (fwd2) begin
      rdata2 = wdata;
    end else if (raddr2 != '0) begin
      rdata2 = regs_q[raddr2];
    end
  end
`else
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) begin
      rdata1 = regs_q[raddr1];
    end
    if (raddr2 != '0) begin
      rdata2 = regs_q[raddr2];
    end
  end
`endif

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32, sets register and data width in bits.
REQ-002 Parameter ADDR_W, default 5, sets register address width; depth = 2**ADDR_W (32).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 we  input  1  write enable for the write port.
REQ-006 waddr  input  ADDR_W  destination register number, normally driven by the 5-bit destination-select mux.
REQ-007 wdata  input  DATA_W  write data, normally driven by the 32-bit write-back mux.
REQ-008 raddr1  input  ADDR_W  read port 1 register number (rs).
REQ-009 raddr2  input  ADDR_W  read port 2 register number (rt).
REQ-010 rdata1  output  DATA_W  read port 1 data.
REQ-011 rdata2  output  DATA_W  read port 2 data.

Function
REQ-012 Storage SHALL be 2**ADDR_W registers of DATA_W bits; register 0 SHALL always read 0.
REQ-013 Write SHALL occur on the rising clk edge when we=1, rst_n=1 and waddr!=0: reg[waddr] <= wdata.
REQ-014 A write with waddr=0 SHALL be discarded, leaving no observable state change.
REQ-015 we=0 SHALL leave every register unchanged regardless of waddr and wdata.
REQ-016 Reads SHALL be combinational with zero-cycle latency: rdataN = reg[raddrN], and rdataN = 0 when raddrN=0.
REQ-017 Both read ports SHALL be fully independent; raddr1=raddr2 SHALL return identical data on both.
REQ-018 Without bypass (see Configuration), a read of the register being written in the same cycle SHALL return the old value, with the new value visible after the edge.
REQ-019 Every register SHALL hold its value indefinitely between writes; there is no wrap-around or overflow behaviour.
REQ-020 X or Z on waddr or wdata while we=0 SHALL NOT corrupt any register.

Reset
REQ-021 rst_n=0 SHALL asynchronously clear all registers to 0, without waiting for a clk edge.
REQ-022 During reset, rdata1 and rdata2 SHALL read 0 for every address.
REQ-023 A write coincident with reset assertion SHALL be discarded.
REQ-024 The first write after rst_n deasserts SHALL take effect on the first rising clk edge at which rst_n=1 and we=1.

Configuration
REQ-025 Macro REG_FILE_BYPASS_EN, when defined, SHALL add write-to-read forwarding: if we=1, waddr!=0 and raddrN=waddr, rdataN SHALL equal wdata combinationally in the same cycle.
REQ-026 With REG_FILE_BYPASS_EN defined, forwarding SHALL be suppressed while rst_n=0 and for waddr=0.
REQ-027 With REG_FILE_BYPASS_EN undefined, no forwarding logic SHALL exist and REQ-018 SHALL apply.

Verification
REQ-028 Assert rst_n=0 mid-cycle after writing reg5=0x1234_5678 -> rdata1 with raddr1=5 reads 0 immediately, before any clk edge.
REQ-029 Set we=1, waddr=0, wdata=0xFFFF_FFFF for one edge -> rdata1 with raddr1=0 reads 0.
REQ-030 Write reg31=0xDEAD_BEEF, then set raddr1=raddr2=31 -> both ports read 0xDEAD_BEEF; reg30 still reads 0.
REQ-031 Drive we=1, waddr=7, wdata=0xA5A5_A5A5, raddr1=7 in one cycle -> before the edge rdata1 shows the old value 0, or 0xA5A5_A5A5 with REG_FILE_BYPASS_EN; after the edge it reads 0xA5A5_A5A5 in both builds.
REQ-032 Drive we=0, waddr=3, wdata=0x1 for 4 cycles after reg3=0x55 -> reg3 still reads 0x55.
REQ-033 Write all 31 nonzero registers with value=address*0x0101_0101, then sweep both read ports -> every read matches and reg0 reads 0.
